// File: rtl/ptr_recycle_pkg.sv
// Shared types and constants for the pointer recycle path.
// Holds default sizing, FSM encoding and the popcount helper.
package ptr_recycle_pkg;

    localparam int DEF_PORTS = 4;
    localparam int DEF_AW    = 10;
    localparam int DEF_DEPTH = 512;
    localparam int DEF_CW    = 3;
    localparam int PTR_OUT_W = 16;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/ptr_recycle_rr_arbiter.sv
// Round-robin arbiter over the release ports.
// The search starts at the port after the last one served.
module rr_arbiter
    import ptr_recycle_pkg::*;
#(
    parameter int PORTS = DEF_PORTS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PORTS-1:0] req_i,
    input  logic             adv_i,
    input  logic [PORTS-1:0] adv_gnt_i,
    output logic [PORTS-1:0] gnt_o
);

    localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PW-1:0] rr_q;
    logic [PW-1:0] rr_d;
    logic          found;
    int            idx;

    // Pick the first requester at or after the round-robin pointer
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < PORTS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!found && req_i[idx[PW-1:0]]) begin
                gnt_o[idx[PW-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
    end

    // Next pointer is one past the port that was just served
    always_comb begin
        rr_d = rr_q;
        for (int i = 0; i < PORTS; i++) begin
            if (adv_i && adv_gnt_i[i]) begin
                rr_d = (i == PORTS - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_q <= '0;
        else      rr_q <= rr_d;
    end

endmodule

// File: rtl/ptr_recycle.sv
// Reference-count return path of the free-pointer queue.
// Counts fan-out per pointer and recycles it when the count hits zero.
module ptr_recycle
    import ptr_recycle_pkg::*;
#(
    parameter int PORTS = DEF_PORTS,
    parameter int AW    = DEF_AW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CW    = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_wr,
    input  logic [AW-1:0]        alloc_ptr,
    input  logic [PORTS-1:0]     alloc_portmap,
    output logic                 alloc_ready,
    input  logic [PORTS-1:0]     rel_req,
    input  logic [PORTS*AW-1:0]  rel_ptr,
    output logic [PORTS-1:0]     rel_ack,
    output logic                 FQ_wr,
    output logic [PTR_OUT_W-1:0] ptr_dout,
    output logic                 init_done,
    output logic                 err_underflow
);

    localparam int IW = $clog2(DEPTH);

    state_t           state_q;
    logic [IW-1:0]    init_cnt_q;
    logic             init_done_q;
    logic [PORTS-1:0] g_q;
    logic [AW-1:0]    ptr_q;
    logic [CW-1:0]    dec_q;
    logic             one_q;
    logic             zero_q;
    logic             err_q;

    logic [PORTS-1:0] gnt;
    logic [AW-1:0]    sel_ptr;
    logic [CW-1:0]    rd_q;
    logic [CW-1:0]    mem [DEPTH];
    logic             we;
    logic [IW-1:0]    wa;
    logic [CW-1:0]    wd;
    logic             alloc_acc;
    logic             bypass;
    logic             retire;
    logic             adv;
    logic [AW-1:0]    out_ptr;

    assign alloc_acc = alloc_wr && init_done_q;
    assign bypass    = alloc_acc && (alloc_portmap == '0);
    assign retire    = (state_q == ST_WB) && !alloc_acc && one_q;
    assign adv       = (state_q == ST_WB) && !alloc_acc;

    rr_arbiter #(.PORTS(PORTS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (rel_req),
        .adv_i     (adv),
        .adv_gnt_i (g_q),
        .gnt_o     (gnt)
    );

    // Pointer of the granted release port
    always_comb begin
        sel_ptr = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (gnt[i]) sel_ptr = rel_ptr[i*AW +: AW];
        end
    end

    // Single RAM write port: init clear, then alloc, then write-back
    always_comb begin
        we = 1'b0;
        wa = '0;
        wd = '0;
        if (state_q == ST_INIT) begin
            we = 1'b1;
            wa = init_cnt_q;
        end else if (alloc_wr && (alloc_portmap != '0)) begin
            we = 1'b1;
            wa = alloc_ptr[IW-1:0];
            wd = CW'(popcount(32'(alloc_portmap)));
        end else if (adv) begin
            we = 1'b1;
            wa = ptr_q[IW-1:0];
            wd = dec_q;
        end
    end

    // Refcount RAM with registered read
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rd_q <= mem[sel_ptr[IW-1:0]];
    end

    // Release FSM: clear RAM, grant, read count, write back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            g_q         <= '0;
            ptr_q       <= '0;
            dec_q       <= '0;
            one_q       <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + IW'(1);
                    if (init_cnt_q == IW'(DEPTH - 1)) begin
                        init_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (|rel_req) begin
                        g_q     <= gnt;
                        ptr_q   <= sel_ptr;
                        state_q <= ST_RD;
                    end
                end
                ST_RD: begin
                    dec_q   <= (rd_q == '0) ? '0 : rd_q - CW'(1);
                    one_q   <= (rd_q == CW'(1));
                    zero_q  <= (rd_q == '0);
                    state_q <= ST_WB;
                end
                ST_WB: begin
                    if (!alloc_acc) begin
                        if (zero_q) err_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign out_ptr       = bypass ? alloc_ptr : (retire ? ptr_q : '0);
    assign ptr_dout      = PTR_OUT_W'(out_ptr);
    assign FQ_wr         = bypass || retire;
    assign rel_ack       = (state_q == ST_IDLE) ? gnt : '0;
    assign alloc_ready   = init_done_q;
    assign init_done     = init_done_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_ptr_recycle.sv
// Testbench for ptr_recycle.
// Scenario tasks with a refcount reference model and event logs.
module tb_ptr_recycle;

    localparam int P  = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          alloc_wr = 1'b0;
    logic [AW-1:0] alloc_ptr = '0;
    logic [P-1:0]  alloc_portmap = '0;
    logic          alloc_ready;
    logic [P-1:0]  rel_req = '0;
    logic [P*AW-1:0] rel_ptr = '0;
    logic [P-1:0]  rel_ack;
    logic          FQ_wr;
    logic [15:0]   ptr_dout;
    logic          init_done;
    logic          err_underflow;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct {
        int          c;
        logic [15:0] p;
    } fq_ev_t;

    typedef struct {
        int            c;
        int            port;
        logic [AW-1:0] p;
    } ack_ev_t;

    fq_ev_t  fq_log[$];
    ack_ev_t ack_log[$];

    ptr_recycle dut (
        .clk           (clk),
        .rst           (rst),
        .alloc_wr      (alloc_wr),
        .alloc_ptr     (alloc_ptr),
        .alloc_portmap (alloc_portmap),
        .alloc_ready   (alloc_ready),
        .rel_req       (rel_req),
        .rel_ptr       (rel_ptr),
        .rel_ack       (rel_ack),
        .FQ_wr         (FQ_wr),
        .ptr_dout      (ptr_dout),
        .init_done     (init_done),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        fq_ev_t  f;
        ack_ev_t a;
        if (FQ_wr) begin
            f.c = cyc_n;
            f.p = ptr_dout;
            fq_log.push_back(f);
        end
        for (int i = 0; i < P; i++) begin
            if (rel_ack[i]) begin
                a.c    = cyc_n;
                a.port = i;
                a.p    = rel_ptr[i*AW +: AW];
                ack_log.push_back(a);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_alloc(input logic [AW-1:0] p, input logic [P-1:0] m,
                            output logic fq, output logic [15:0] d);
        tick();
        alloc_wr = 1'b1;
        alloc_ptr = p;
        alloc_portmap = m;
        @(negedge clk);
        fq = FQ_wr;
        d = ptr_dout;
        tick();
        alloc_wr = 1'b0;
    endtask

    task automatic rel_one(input int port, input logic [AW-1:0] p,
                           output int ack_c);
        tick();
        rel_req = P'(1) << port;
        rel_ptr[port*AW +: AW] = p;
        ack_c = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rel_ack[port]) begin
                ack_c = cyc_n;
                break;
            end
        end
        tick();
        rel_req = '0;
    endtask

    task automatic test_reset();
        int n;
        int bad;
        bit done;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (FQ_wr !== 1'b0) begin
            errors++; $display("FAIL reset_fq got %b want 0", FQ_wr);
        end
        checks++;
        if (rel_ack !== 4'b0) begin
            errors++; $display("FAIL reset_ack got %b want 0", rel_ack);
        end
        checks++;
        if (init_done !== 1'b0 || alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_init got %b/%b want 0/0", init_done, alloc_ready);
        end
        checks++;
        if (err_underflow !== 1'b0 || ptr_dout !== 16'h0) begin
            errors++;
            $display("FAIL reset_err got %b/%h want 0/0000", err_underflow, ptr_dout);
        end
        fq_log.delete();
        ack_log.delete();
        tick();
        rst = 1'b1;
        rel_req = 4'hF;
        rel_ptr = {4{10'h003}};
        alloc_wr = 1'b1;
        alloc_ptr = 10'h003;
        alloc_portmap = '0;
        n = 0;
        bad = 0;
        done = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            @(posedge clk);
            n++;
            if (n == 100) begin
                #1;
                rel_req = '0;
                alloc_wr = 1'b0;
            end
            @(negedge clk);
            if (init_done) done = 1'b1;
            else if (alloc_ready || rel_ack != '0 || FQ_wr) bad++;
        end
        checks++;
        if (!done || n != 512) begin
            errors++; $display("FAIL init_len got %0d want 512", n);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL init_quiet got %0d active cycles want 0", bad);
        end
        checks++;
        if (fq_log.size() != 0 || ack_log.size() != 0) begin
            errors++;
            $display("FAIL init_events got fq=%0d ack=%0d want 0/0",
                     fq_log.size(), ack_log.size());
        end
        checks++;
        if (alloc_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_init got %b want 1", alloc_ready);
        end
    endtask

    task automatic test_fanout();
        logic fq;
        logic [15:0] d;
        int a0, a1, a2, s;
        do_alloc(10'h005, 4'b1011, fq, d);
        checks++;
        if (fq !== 1'b0) begin
            errors++; $display("FAIL fanout_alloc_fq got %b want 0", fq);
        end
        s = fq_log.size();
        rel_one(0, 10'h005, a0);
        rel_one(1, 10'h005, a1);
        rel_one(3, 10'h005, a2);
        repeat (4) tick();
        checks++;
        if (a0 < 0 || a1 < 0 || a2 < 0) begin
            errors++; $display("FAIL fanout_acks got %0d,%0d,%0d want all >=0", a0, a1, a2);
        end
        checks++;
        if (fq_log.size() - s != 1) begin
            errors++; $display("FAIL fanout_fq_cnt got %0d want 1", fq_log.size() - s);
        end else begin
            checks++;
            if (fq_log[s].p !== 16'h0005 || fq_log[s].c != a2 + 2) begin
                errors++;
                $display("FAIL fanout_fq got %h@%0d want 0005@%0d",
                         fq_log[s].p, fq_log[s].c, a2 + 2);
            end
        end
    endtask

    task automatic test_rr();
        logic fq;
        logic [15:0] d;
        logic [P-1:0] pend;
        int a, s_fq, s_ack;
        int exp_ord[4] = '{2, 3, 0, 1};
        do_alloc(10'h00B, 4'b0010, fq, d);
        s_fq = fq_log.size();
        rel_one(1, 10'h00B, a);
        repeat (4) tick();
        checks++;
        if (fq_log.size() - s_fq != 1 || fq_log[s_fq].p !== 16'h000B) begin
            errors++; $display("FAIL rr_setup_fq got %0d events want one 000B",
                               fq_log.size() - s_fq);
        end
        do_alloc(10'h00A, 4'b1111, fq, d);
        s_fq = fq_log.size();
        s_ack = ack_log.size();
        tick();
        rel_req = 4'hF;
        rel_ptr = {4{10'h00A}};
        for (int k = 0; k < 40 && rel_req != '0; k++) begin
            @(negedge clk);
            pend = rel_ack;
            tick();
            rel_req = rel_req & ~pend;
        end
        rel_req = '0;
        repeat (4) tick();
        checks++;
        if (ack_log.size() - s_ack != 4) begin
            errors++; $display("FAIL rr_ack_cnt got %0d want 4", ack_log.size() - s_ack);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ack_log[s_ack+i].port != exp_ord[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d] got %0d want %0d",
                             i, ack_log[s_ack+i].port, exp_ord[i]);
                end
                if (i > 0) begin
                    checks++;
                    if (ack_log[s_ack+i].c - ack_log[s_ack+i-1].c != 3) begin
                        errors++;
                        $display("FAIL rr_spacing[%0d] got %0d want 3", i,
                                 ack_log[s_ack+i].c - ack_log[s_ack+i-1].c);
                    end
                end
            end
            checks++;
            if (fq_log.size() - s_fq != 1 || fq_log[s_fq].p !== 16'h000A ||
                fq_log[s_fq].c != ack_log[s_ack+3].c + 2) begin
                errors++; $display("FAIL rr_fq got %0d events want one 000A at last+2",
                                   fq_log.size() - s_fq);
            end
        end
    endtask

    task automatic test_bypass();
        logic fq;
        logic [15:0] d;
        int s;
        s = fq_log.size();
        do_alloc(10'h1FF, 4'b0000, fq, d);
        checks++;
        if (fq !== 1'b1 || d !== 16'h01FF) begin
            errors++; $display("FAIL bypass got %b/%h want 1/01ff", fq, d);
        end
        repeat (2) tick();
        checks++;
        if (fq_log.size() - s != 1) begin
            errors++; $display("FAIL bypass_once got %0d want 1", fq_log.size() - s);
        end
    endtask

    task automatic test_conflict();
        logic fq;
        logic [15:0] d;
        int s;
        bit acked;
        do_alloc(10'h010, 4'b0001, fq, d);
        s = fq_log.size();
        tick();
        rel_req = 4'b0001;
        rel_ptr[0 +: AW] = 10'h010;
        acked = 1'b0;
        for (int k = 0; k < 20 && !acked; k++) begin
            @(negedge clk);
            if (rel_ack[0]) acked = 1'b1;
            else tick();
        end
        checks++;
        if (!acked) begin
            errors++; $display("FAIL conflict_ack got none want ack");
        end
        tick();
        rel_req = '0;
        tick();
        alloc_wr = 1'b1;
        alloc_ptr = 10'h020;
        alloc_portmap = '0;
        @(negedge clk);
        checks++;
        if (FQ_wr !== 1'b1 || ptr_dout !== 16'h0020) begin
            errors++; $display("FAIL conflict_first got %b/%h want 1/0020", FQ_wr, ptr_dout);
        end
        tick();
        alloc_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (FQ_wr !== 1'b1 || ptr_dout !== 16'h0010) begin
            errors++; $display("FAIL conflict_second got %b/%h want 1/0010", FQ_wr, ptr_dout);
        end
        repeat (3) tick();
        checks++;
        if (fq_log.size() - s != 2) begin
            errors++; $display("FAIL conflict_cnt got %0d want 2", fq_log.size() - s);
        end
    endtask

    task automatic test_random();
        logic fq;
        logic [15:0] d;
        logic [AW-1:0] pq[P][$];
        logic [AW-1:0] ptrs[8];
        logic [P-1:0] m;
        logic [P-1:0] pend;
        int ref_cnt[512];
        fq_ev_t exp_fq[$];
        fq_ev_t e;
        int s_fq, s_ack, bad_ack, bad_gap, bad_fq;
        bit dup, empty;
        foreach (ref_cnt[i]) ref_cnt[i] = 0;
        for (int i = 0; i < 8; i++) begin
            do begin
                ptrs[i] = AW'(256 + $urandom_range(0, 239));
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (ptrs[j] == ptrs[i]) dup = 1'b1;
            end while (dup);
        end
        for (int i = 0; i < 8; i++) begin
            m = P'($urandom_range(1, 15));
            do_alloc(ptrs[i], m, fq, d);
            ref_cnt[ptrs[i]] = $countones(m);
            for (int p = 0; p < P; p++) if (m[p]) pq[p].push_back(ptrs[i]);
        end
        s_fq = fq_log.size();
        s_ack = ack_log.size();
        empty = 1'b0;
        for (int k = 0; k < 3000 && !empty; k++) begin
            for (int p = 0; p < P; p++) begin
                if (!rel_req[p] && pq[p].size() > 0 && $urandom_range(0, 1) == 1) begin
                    rel_req[p] = 1'b1;
                    rel_ptr[p*AW +: AW] = pq[p][0];
                end
            end
            @(negedge clk);
            pend = rel_ack;
            tick();
            for (int p = 0; p < P; p++) begin
                if (pend[p]) begin
                    rel_req[p] = 1'b0;
                    void'(pq[p].pop_front());
                end
            end
            empty = 1'b1;
            for (int p = 0; p < P; p++) if (pq[p].size() > 0) empty = 1'b0;
        end
        rel_req = '0;
        repeat (5) tick();
        checks++;
        if (!empty) begin
            errors++; $display("FAIL rand_drain got pending releases want none");
        end
        bad_ack = 0;
        bad_gap = 0;
        for (int i = s_ack; i < ack_log.size(); i++) begin
            if (ref_cnt[ack_log[i].p] == 0) bad_ack++;
            else begin
                ref_cnt[ack_log[i].p]--;
                if (ref_cnt[ack_log[i].p] == 0) begin
                    e.c = ack_log[i].c + 2;
                    e.p = 16'(ack_log[i].p);
                    exp_fq.push_back(e);
                end
            end
            if (i > s_ack && ack_log[i].c - ack_log[i-1].c < 3) bad_gap++;
        end
        checks++;
        if (bad_ack != 0) begin
            errors++; $display("FAIL rand_ack_ptr got %0d stray acks want 0", bad_ack);
        end
        checks++;
        if (bad_gap != 0) begin
            errors++; $display("FAIL rand_ack_gap got %0d close acks want 0", bad_gap);
        end
        checks++;
        if (fq_log.size() - s_fq != 8 || exp_fq.size() != 8) begin
            errors++; $display("FAIL rand_fq_cnt got %0d/%0d want 8",
                               fq_log.size() - s_fq, exp_fq.size());
        end else begin
            bad_fq = 0;
            for (int i = 0; i < 8; i++) begin
                if (fq_log[s_fq+i].p !== exp_fq[i].p || fq_log[s_fq+i].c != exp_fq[i].c)
                    bad_fq++;
            end
            checks++;
            if (bad_fq != 0) begin
                errors++; $display("FAIL rand_fq_match got %0d wrong want 0", bad_fq);
            end
        end
    endtask

    task automatic test_underflow();
        int a, s;
        s = fq_log.size();
        rel_one(2, 10'h030, a);
        repeat (5) tick();
        checks++;
        if (a < 0) begin
            errors++; $display("FAIL uf_ack got none want ack");
        end
        checks++;
        if (fq_log.size() != s) begin
            errors++; $display("FAIL uf_fq got %0d events want 0", fq_log.size() - s);
        end
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++; $display("FAIL uf_flag got %b want 1", err_underflow);
        end
        repeat (20) tick();
        checks++;
        if (err_underflow !== 1'b1) begin
            errors++; $display("FAIL uf_sticky got %b want 1", err_underflow);
        end
    endtask

    task automatic test_midreset();
        logic fq;
        logic [15:0] d;
        int s;
        bit acked;
        do_alloc(10'h040, 4'b0001, fq, d);
        s = fq_log.size();
        tick();
        rel_req = 4'b0001;
        rel_ptr[0 +: AW] = 10'h040;
        acked = 1'b0;
        for (int k = 0; k < 20 && !acked; k++) begin
            @(negedge clk);
            if (rel_ack[0]) acked = 1'b1;
            else tick();
        end
        tick();
        rst = 1'b0;
        rel_req = '0;
        @(negedge clk);
        checks++;
        if (!acked || init_done !== 1'b0 || alloc_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_state got ack=%b init=%b rdy=%b want 1/0/0",
                               acked, init_done, alloc_ready);
        end
        checks++;
        if (err_underflow !== 1'b0) begin
            errors++; $display("FAIL midrst_err got %b want 0", err_underflow);
        end
        repeat (5) tick();
        checks++;
        if (fq_log.size() != s) begin
            errors++; $display("FAIL midrst_fq got %0d events want 0", fq_log.size() - s);
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fanout();
        test_rr();
        test_bypass();
        test_conflict();
        test_random();
        test_underflow();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
